// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding and
// the legal range for the number of beats per instruction.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DONE  = 2'b10
  } fetchState_t;

  localparam int INSTR_BYTES_MIN = 1;
  localparam int INSTR_BYTES_MAX = 4;

  function automatic bit instrBytesLegal(input int n);
    return (n >= INSTR_BYTES_MIN) && (n <= INSTR_BYTES_MAX);
  endfunction

endpackage

// File: rtl/fetch_beat_buffer.sv
// Shadow buffer and beat counter: gathers memory beats least-significant first
// and commits the finished word to the instruction register in one edge.
module fetch_beat_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_BYTES = 2,
  parameter int CNT_W       = 1
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              capture,
  input  logic                              clear,
  input  logic                              last,
  input  logic [DATA_WIDTH-1:0]             memOut,
  output logic [CNT_W-1:0]                  beatCount,
  output logic [INSTR_BYTES*DATA_WIDTH-1:0] irOut
);

  localparam int WORD_W = INSTR_BYTES * DATA_WIDTH;

  logic [WORD_W-1:0] shadowReg;
  logic [WORD_W-1:0] irReg;
  logic [WORD_W-1:0] commitWord;
  logic [CNT_W-1:0]  countReg;

  // The slot addressed by the counter takes live memory data so the final beat
  // reaches the instruction register on the same edge it is read.
  genvar gi;
  generate
    for (gi = 0; gi < INSTR_BYTES; gi++) begin : gSlot
      assign commitWord[DATA_WIDTH*gi +: DATA_WIDTH] =
        (countReg == CNT_W'(gi)) ? memOut : shadowReg[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadowReg <= '0;
      countReg  <= '0;
      irReg     <= '0;
    end else if (clear) begin
      shadowReg <= '0;
      countReg  <= '0;
    end else if (capture) begin
      shadowReg <= commitWord;
      if (last) begin
        irReg    <= commitWord;
        countReg <= '0;
      end else begin
        countReg <= countReg + CNT_W'(1);
      end
    end
  end

  assign beatCount = countReg;
  assign irOut     = irReg;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Multi-beat instruction fetch: owns the PC, drives the byte-wide read port and
// sequences IDLE -> FETCH -> DONE with stall, flush and PC reload.
module instruction_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_BYTES = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int RESET_PC    = 0
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              Start,
  input  logic                              Stall,
  input  logic                              Flush,
  input  logic                              PC_Load,
  input  logic [ADDR_WIDTH-1:0]             PC_In,
  input  logic [DATA_WIDTH-1:0]             MemOut,
  output logic [ADDR_WIDTH-1:0]             Address,
  output logic                              Mem_CS,
  output logic                              Mem_WR,
  output logic [ADDR_WIDTH-1:0]             PC,
  output logic [INSTR_BYTES*DATA_WIDTH-1:0] IROut,
  output logic                              Busy,
  output logic                              Done
);

  localparam int CNT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

  generate
    if (!instrBytesLegal(INSTR_BYTES)) begin : gIllegalInstrBytes
      $error("instruction_fetch_sequencer: INSTR_BYTES must be 1..4");
    end
  endgenerate

  fetchState_t           state;
  logic [ADDR_WIDTH-1:0] pcReg;
  logic [CNT_W-1:0]      beatCount;
  logic                  busyReg;
  logic                  doneReg;
  logic                  inFetch;
  logic                  beatCapture;
  logic                  bufClear;
  logic                  lastBeat;

  assign inFetch     = (state == FETCH);
  assign beatCapture = inFetch && !Stall && !Flush;
  assign bufClear    = Flush || (state == IDLE);
  assign lastBeat    = (beatCount == CNT_W'(INSTR_BYTES - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else if (Flush) begin
      state   <= IDLE;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (Start) begin
            state   <= FETCH;
            busyReg <= 1'b1;
          end
        end
        FETCH: begin
          if (!Stall && lastBeat) begin
            state   <= DONE;
            doneReg <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busyReg <= 1'b0;
          doneReg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
          doneReg <= 1'b0;
        end
      endcase
    end
  end

  // A reload wins over the increment, but a fetch in flight only yields to it under flush.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pcReg <= ADDR_WIDTH'(RESET_PC);
    end else if (PC_Load && (Flush || !inFetch)) begin
      pcReg <= PC_In;
    end else if (beatCapture) begin
      pcReg <= pcReg + ADDR_WIDTH'(1);
    end
  end

  fetch_beat_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .INSTR_BYTES(INSTR_BYTES),
    .CNT_W      (CNT_W)
  ) beatBuffer (
    .Clock    (Clock),
    .Reset    (Reset),
    .capture  (beatCapture),
    .clear    (bufClear),
    .last     (lastBeat),
    .memOut   (MemOut),
    .beatCount(beatCount),
    .irOut    (IROut)
  );

  assign Address = pcReg;
  assign PC      = pcReg;
  assign Mem_CS  = !inFetch;
  assign Mem_WR  = 1'b0;
  assign Busy    = busyReg;
  assign Done    = doneReg;

endmodule
